// File: rtl/vram_arb_if.sv
// vram_arb_if: bundles the CPU port, video fetch port and RAM port of vram_arb.
//   cpu_*  : CPU word read/write requests (level) and completion pulses
//   vid_*  : scan-out read requests (level) and completion pulse
//   mem_*  : single-ported RAM strobe, address, write data and read data
//   slave  : arbiter side; master : requester/RAM side
interface vram_arb_if;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_req;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [14:0] vid_addr;
    logic        vid_req;
    logic [31:0] vid_rdata;
    logic        vid_ready;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ce;
    logic [31:0] mem_rdata;
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_req, cpu_write, vid_addr, vid_req, mem_rdata,
        output cpu_rdata, cpu_ready, cpu_done, vid_rdata, vid_ready,
               mem_addr, mem_wdata, mem_we, mem_ce
    );
    modport master (
        output cpu_addr, cpu_wdata, cpu_req, cpu_write, vid_addr, vid_req, mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_done, vid_rdata, vid_ready,
               mem_addr, mem_wdata, mem_we, mem_ce
    );
endinterface

// File: rtl/vram_arb.sv
// vram_arb: shares the single-ported video RAM between the CPU port and the
// video scan-out fetch port, one access at a time, video first with a
// starvation bound for the CPU.
//   clk     : sole clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : vram_arb_if.slave (CPU port, video port, RAM port)
module vram_arb #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input logic       clk,
    input logic       reset_n,
    vram_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t      r_state;
    logic        r_win_cpu;
    logic        r_win_we;
    logic        r_hold;
    logic [3:0]  r_starve;
    logic [2:0]  r_lat;
    logic [14:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_ce;
    logic        r_mem_we;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_vid_rdata;
    logic        r_cpu_ready;
    logic        r_cpu_done;
    logic        r_vid_ready;
    logic        w_cpu_raw;
    logic        w_cpu_win;
    logic        w_vid_win;
    logic        w_starve_max;
    assign w_cpu_raw    = bus.cpu_req | bus.cpu_write;
    assign w_starve_max = r_starve == 4'(STARVE_MAX);
    // r_hold masks the CPU level that the requester keeps for one cycle after its pulse
    assign w_cpu_win    = w_cpu_raw & ~r_hold & (~bus.vid_req | w_starve_max);
    assign w_vid_win    = bus.vid_req & ~w_cpu_win;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_win_cpu   <= 1'b0;
            r_win_we    <= 1'b0;
            r_hold      <= 1'b0;
            r_starve    <= '0;
            r_lat       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_vid_ready <= 1'b0;
        end else begin
            r_hold <= (r_state == RESP) && r_win_cpu;
            case (r_state)
                IDLE: begin
                    if (w_cpu_win || w_vid_win) begin
                        r_state    <= ACCESS;
                        r_win_cpu  <= w_cpu_win;
                        r_win_we   <= w_cpu_win & bus.cpu_write;
                        r_mem_ce   <= 1'b1;
                        r_mem_we   <= w_cpu_win & bus.cpu_write;
                        r_mem_addr <= w_cpu_win ? bus.cpu_addr : bus.vid_addr;
                        if (w_cpu_win && bus.cpu_write)
                            r_mem_wdata <= bus.cpu_wdata;
                        // the raw CPU level counts as pending so a held request sees a fixed ratio
                        r_starve <= w_cpu_win ? '0 :
                                    (w_cpu_raw && !w_starve_max) ? r_starve + 4'd1 : r_starve;
                    end
                end
                ACCESS: begin
                    r_mem_ce   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_lat      <= '0;
                    r_cpu_done <= r_win_we;
                    r_state    <= r_win_we ? RESP : WAIT;
                end
                WAIT: begin
                    if (r_lat == 3'(MEM_LAT - 1)) begin
                        r_state <= RESP;
                        if (r_win_cpu) begin
                            r_cpu_rdata <= bus.mem_rdata;
                            r_cpu_ready <= 1'b1;
                        end else begin
                            r_vid_rdata <= bus.mem_rdata;
                            r_vid_ready <= 1'b1;
                        end
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                RESP: begin
                    r_cpu_ready <= 1'b0;
                    r_cpu_done  <= 1'b0;
                    r_vid_ready <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_ce    = r_mem_ce;
    assign bus.mem_we    = r_mem_we;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_done  = r_cpu_done;
    assign bus.vid_rdata = r_vid_rdata;
    assign bus.vid_ready = r_vid_ready;
endmodule
